// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the keypad scanner: default parameters and FSM encoding.
package keypad_pkg;

    localparam int DEF_NROW     = 4;
    localparam int DEF_NCOL     = 4;
    localparam int DEF_SCAN_CYC = 4;
    localparam int DEF_DEB_CYC  = 5;
    localparam int DEF_LONG_CYC = 50;
    localparam int DEF_REP_CYC  = 10;

    typedef logic [1:0] state_t;

    localparam state_t SCAN  = 2'd0;
    localparam state_t DEB_P = 2'd1;
    localparam state_t HELD  = 2'd2;
    localparam state_t DEB_R = 2'd3;

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops give a metastable first stage a full cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Keypad scanner: walks an active-low row strobe, locks onto the first key it
// finds, debounces it and reports press, long-press, auto-repeat and release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int  NROW     = DEF_NROW,
    parameter int  NCOL     = DEF_NCOL,
    parameter int  SCAN_CYC = DEF_SCAN_CYC,
    parameter int  DEB_CYC  = DEF_DEB_CYC,
    parameter int  LONG_CYC = DEF_LONG_CYC,
    parameter int  REP_CYC  = DEF_REP_CYC,
    localparam int CW       = $clog2(NROW * NCOL)
) (
    input  logic            Clk1,
    input  logic            Rst,
    input  logic [NCOL-1:0] Column,
    output logic [NROW-1:0] Row,
    output logic [CW-1:0]   Value,
    output logic            flag,
    output logic            Press,
    output logic            Long,
    output logic            Repeat,
    output logic            Release
);

    localparam int RW = $clog2(NROW);
    localparam int KW = $clog2(NCOL);
    localparam int SW = $clog2(SCAN_CYC);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + REP_CYC + 1);

    localparam logic [RW-1:0] ROW_LAST  = RW'(NROW - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYC - 1);
    localparam logic [DW-1:0] DEB_DONE  = DW'(DEB_CYC);
    localparam logic [HW-1:0] LONG_AT   = HW'(LONG_CYC);
    localparam logic [HW-1:0] REP_AT    = HW'(REP_CYC);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC + REP_CYC);

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [SW-1:0]   dwell_q, dwell_d;
    logic [KW-1:0]   col_q, col_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [HW-1:0]   rep_q, rep_d;
    logic [CW-1:0]   value_q, value_d;
    logic            flag_q, flag_d;
    logic            press_q, press_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;
    logic            release_q, release_d;

    logic [NCOL-1:0] col_sync;
    logic            any_low;
    logic [KW-1:0]   low_idx;
    logic            key_low;
    logic [RW-1:0]   row_next;
    logic [DW-1:0]   deb_inc;
    logic [CW-1:0]   key_code;
    logic [HW-1:0]   hold_inc;
    logic [HW-1:0]   rep_inc;
    logic            long_hit;
    logic            rep_hit;

    sync2 #(
        .WIDTH   (NCOL),
        .RST_VAL ({NCOL{1'b1}})
    ) u_sync (
        .clk (Clk1),
        .rst (Rst),
        .d   (Column),
        .q   (col_sync)
    );

    // Active-low one-hot strobe for the current (or locked) row.
    always_comb begin
        Row        = '1;
        Row[row_q] = 1'b0;
    end

    // Column lookup: lowest pressed column, state of the locked column, next row, key code.
    always_comb begin
        low_idx = '0;
        for (int i = NCOL - 1; i >= 0; i--) begin
            if (!col_sync[i]) begin
                low_idx = KW'(i);
            end
        end
        any_low  = ~&col_sync;
        key_low  = ~col_sync[col_q];
        row_next = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        deb_inc  = deb_q + DW'(1);
        key_code = CW'(int'(row_q) * NCOL + int'(col_q));
    end

    // Hold timing shared by HELD and DEB_R so a short bounce does not shift Long/Repeat.
    always_comb begin
        hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        long_hit = (hold_q != LONG_AT) && (hold_inc == LONG_AT);
        rep_inc  = rep_q;
        rep_hit  = 1'b0;
        if (hold_q >= LONG_AT) begin
            if (rep_q + HW'(1) == REP_AT) begin
                rep_hit = 1'b1;
                rep_inc = '0;
            end else begin
                rep_inc = rep_q + HW'(1);
            end
        end
    end

    // Scan / debounce / hold state machine; only one key is tracked while locked.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        dwell_d   = dwell_q;
        col_d     = col_q;
        deb_d     = deb_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        value_d   = value_q;
        flag_d    = flag_q;
        press_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        release_d = 1'b0;
        case (state_q)
            SCAN: begin
                if (dwell_q == SCAN_LAST) begin
                    dwell_d = '0;
                    if (any_low) begin
                        col_d   = low_idx;
                        deb_d   = '0;
                        state_d = DEB_P;
                    end else begin
                        row_d = row_next;
                    end
                end else begin
                    dwell_d = dwell_q + SW'(1);
                end
            end
            DEB_P: begin
                if (key_low) begin
                    if (deb_inc == DEB_DONE) begin
                        state_d = HELD;
                        deb_d   = '0;
                        hold_d  = '0;
                        rep_d   = '0;
                        value_d = key_code;
                        flag_d  = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        deb_d = deb_inc;
                    end
                end else begin
                    deb_d   = '0;
                    state_d = SCAN;
                    row_d   = row_next;
                end
            end
            HELD: begin
                hold_d   = hold_inc;
                rep_d    = rep_inc;
                long_d   = long_hit;
                repeat_d = rep_hit;
                if (!key_low) begin
                    state_d = DEB_R;
                    deb_d   = '0;
                end
            end
            DEB_R: begin
                if (!key_low && deb_inc == DEB_DONE) begin
                    release_d = 1'b1;
                    flag_d    = 1'b0;
                    state_d   = SCAN;
                    row_d     = row_next;
                    deb_d     = '0;
                    hold_d    = '0;
                    rep_d     = '0;
                end else begin
                    hold_d   = hold_inc;
                    rep_d    = rep_inc;
                    long_d   = long_hit;
                    repeat_d = rep_hit;
                    if (key_low) begin
                        state_d = HELD;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_inc;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // State and output registers with synchronous reset back to idle scanning of row 0.
    always_ff @(posedge Clk1) begin
        if (Rst) begin
            state_q   <= SCAN;
            row_q     <= '0;
            dwell_q   <= '0;
            col_q     <= '0;
            deb_q     <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            value_q   <= '0;
            flag_q    <= 1'b0;
            press_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            value_q   <= value_d;
            flag_q    <= flag_d;
            press_q   <= press_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            release_q <= release_d;
        end
    end

    assign Value   = value_q;
    assign flag    = flag_q;
    assign Press   = press_q;
    assign Long    = long_q;
    assign Repeat  = repeat_q;
    assign Release = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a default 4x4 instance and a 2x8 instance, each
// fed by a switch-matrix model, with events logged and compared against a timing model.
module tb_keypad_scanner;

    localparam int NC   = 4;
    localparam int DEB  = 5;
    localparam int LONG = 50;
    localparam int REP  = 10;

    logic        clk = 1'b0;
    logic        Rst;
    logic [15:0] keys1 = '0;
    logic [15:0] keys2 = '0;

    logic [3:0]  row1, col1, value1;
    logic        flag1, press1, long1, rep1, rel1;
    logic [1:0]  row2;
    logic [7:0]  col2;
    logic [3:0]  value2;
    logic        flag2, press2, long2, rep2, rel2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int press_t[$];
    int press_v[$];
    int long_t[$];
    int rep_t[$];
    int rel_t[$];
    int multi_n  = 0;
    int flag_hi  = 0;
    int press2_n = 0;
    int rel2_n   = 0;

    always #5 clk = ~clk;

    keypad_scanner dut1 (
        .Clk1(clk), .Rst(Rst), .Column(col1), .Row(row1), .Value(value1), .flag(flag1),
        .Press(press1), .Long(long1), .Repeat(rep1), .Release(rel1)
    );

    keypad_scanner #(.NROW(2), .NCOL(8)) dut2 (
        .Clk1(clk), .Rst(Rst), .Column(col2), .Row(row2), .Value(value2), .flag(flag2),
        .Press(press2), .Long(long2), .Repeat(rep2), .Release(rel2)
    );

    // Switch matrix: a closed key pulls its column low while its row is strobed.
    always_comb begin
        col1 = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys1[r*4+c] && !row1[r]) col1[c] = 1'b0;
        col2 = '1;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++)
                if (keys2[r*8+c] && !row2[r]) col2[c] = 1'b0;
    end

    // Event log: cycle stamp of every pulse, sampled just after the clock edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (press1) begin
            press_t.push_back(cyc);
            press_v.push_back(int'(value1));
        end
        if (long1) long_t.push_back(cyc);
        if (rep1)  rep_t.push_back(cyc);
        if (rel1)  rel_t.push_back(cyc);
        if (flag1) flag_hi++;
        if (int'(press1) + int'(long1) + int'(rep1) + int'(rel1) > 1) multi_n++;
        if (int'(press2) + int'(long2) + int'(rep2) + int'(rel2) > 1) multi_n++;
        if (press2) press2_n++;
        if (rel2)   rel2_n++;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input int got, input int lo, input int hi);
        n_checks++;
        assert (got >= lo && got <= hi) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    function automatic int count_of(input int sel);
        case (sel)
            0:       return press_t.size();
            3:       return rel_t.size();
            4:       return press2_n;
            5:       return rel2_n;
            default: return 0;
        endcase
    endfunction

    task automatic wait_count(input int sel, input int want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (count_of(sel) >= want) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_row(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && row1 == target; i++) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            if (row1 == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic clear_log();
        press_t.delete();
        press_v.delete();
        long_t.delete();
        rep_t.delete();
        rel_t.delete();
        flag_hi = 0;
    endtask

    // Hold one key for n cycles after its Press; with glitch, bounce it open for 2 cycles at +20.
    task automatic apply_stimulus(input int r, input int c, input int n, input bit glitch);
        int tp, topen, exp_rep;
        bit ok;
        clear_log();
        keys1[r*4+c] = 1'b1;
        wait_count(0, 1, ok);
        check_output("press_seen", ok, 1);
        if (!ok) begin
            keys1 = '0;
            repeat (60) @(negedge clk);
            return;
        end
        tp = press_t[0];
        check_output("press_value", press_v[0], r * NC + c);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (glitch && i == 20) keys1[r*4+c] = 1'b0;
            if (glitch && i == 22) keys1[r*4+c] = 1'b1;
        end
        check_output("flag_held", flag1, 1);
        topen = cyc;
        keys1[r*4+c] = 1'b0;
        wait_count(3, 1, ok);
        check_output("release_seen", ok, 1);
        repeat (4) @(negedge clk);
        check_output("press_count", press_t.size(), 1);
        check_output("long_count", long_t.size(), (n >= LONG) ? 1 : 0);
        if (long_t.size() > 0) check_output("long_offset", long_t[0] - tp, LONG);
        exp_rep = (n >= LONG + REP) ? (n - LONG - REP) / REP + 1 : 0;
        check_output("repeat_count", rep_t.size(), exp_rep);
        for (int k = 0; k < rep_t.size() && k < exp_rep; k++)
            check_output("repeat_offset", rep_t[k] - tp, LONG + REP * (k + 1));
        check_output("release_count", rel_t.size(), 1);
        if (rel_t.size() > 0) check_range("release_delay", rel_t[0] - topen, DEB, DEB + 4);
        check_output("flag_after", flag1, 0);
        check_output("value_kept", value1, r * NC + c);
    endtask

    initial begin
        bit ok;
        int stay, r, c, t2;

        Rst = 1'b1;
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        check_output("reset_row", row1, 4'b1110);
        check_output("reset_value", value1, 0);
        check_output("reset_flag", flag1, 0);
        check_output("reset_pulses", {press1, long1, rep1, rel1}, 0);

        // 2x8 instance: idle row alternation, then key (1,7)
        for (int k = 0; k < 12; k++) begin
            check_output("idle_row_2x8", row2, ((k / 4) % 2 == 0) ? 2'b10 : 2'b01);
            @(negedge clk);
        end
        keys2[1*8+7] = 1'b1;
        wait_count(4, 1, ok);
        check_output("press_2x8_seen", ok, 1);
        check_output("value_2x8", value2, 15);
        check_output("flag_2x8", flag2, 1);
        keys2 = '0;
        wait_count(5, 1, ok);
        check_output("release_2x8_seen", ok, 1);
        @(negedge clk);
        check_output("flag_2x8_after", flag2, 0);

        // Long hold of (1,2) with long press and repeats
        apply_stimulus(1, 2, 121, 1'b0);

        // Short bounce on (3,0): no events, scan resumes at row 0
        clear_log();
        wait_row(4'b0111, ok);
        check_output("row3_seen", ok, 1);
        keys1[3*4+0] = 1'b1;
        repeat (3) @(negedge clk);
        keys1[3*4+0] = 1'b0;
        stay = 0;
        for (int i = 0; i < 20 && row1 == 4'b0111; i++) begin
            stay++;
            @(negedge clk);
        end
        check_output("resume_row", row1, 4'b1110);
        check_range("resume_delay", stay, 0, 4);
        repeat (20) @(negedge clk);
        check_output("bounce_pulses", press_t.size() + long_t.size() + rep_t.size() + rel_t.size(), 0);
        check_output("bounce_flag", flag_hi, 0);

        // Release glitch on (0,0) must not disturb the hold
        apply_stimulus(0, 0, 61, 1'b1);

        // Two keys together: (0,3) wins, (2,1) reported after it releases
        clear_log();
        wait_row(4'b1110, ok);
        keys1[0*4+3] = 1'b1;
        keys1[2*4+1] = 1'b1;
        wait_count(0, 1, ok);
        check_output("dual_first_seen", ok, 1);
        if (ok) check_output("dual_first_value", press_v[0], 3);
        repeat (30) @(negedge clk);
        check_output("dual_locked_count", press_t.size(), 1);
        check_output("dual_locked_value", value1, 3);
        keys1[0*4+3] = 1'b0;
        wait_count(3, 1, ok);
        check_output("dual_release_seen", ok, 1);
        wait_count(0, 2, ok);
        check_output("dual_second_seen", ok, 1);
        if (ok) begin
            check_output("dual_second_value", press_v[1], 9);
            check_output("dual_second_after_release", press_t[1] > rel_t[0], 1);
        end
        keys1 = '0;
        wait_count(3, 2, ok);
        check_output("dual_second_release", ok, 1);

        // Randomized keys and hold lengths against the timing model
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            apply_stimulus($urandom_range(0, 3), $urandom_range(0, 3), 10 * $urandom_range(0, 8) + 1, 1'b0);
        end

        // Reset during HELD: immediate return to idle with no Release
        clear_log();
        r = $urandom_range(1, 3);
        c = $urandom_range(0, 3);
        keys1[r*4+c] = 1'b1;
        wait_count(0, 1, ok);
        check_output("rst_press_seen", ok, 1);
        t2 = $urandom_range(5, 30);
        repeat (t2) @(negedge clk);
        check_output("rst_flag_before", flag1, 1);
        Rst = 1'b1;
        @(negedge clk);
        Rst = 1'b0;
        keys1 = '0;
        check_output("rst_row", row1, 4'b1110);
        check_output("rst_flag", flag1, 0);
        check_output("rst_value", value1, 0);
        check_output("rst_pulses", {press1, long1, rep1, rel1}, 0);
        repeat (30) @(negedge clk);
        check_output("rst_no_release", rel_t.size(), 0);
        check_output("rst_no_new_press", press_t.size(), 1);

        check_output("one_hot_pulses", multi_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
